store_bram_q_k_v: RTL and testbench

STORE_BRAM_Q_K_V -- requirements
Module: store_bram_q_k_v

---
 rtl/store_bram_q_k_v.sv | 119 +++++++++++
 tb/tb_store_bram_q_k_v.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_bram_q_k_v.sv
// Streams one Q/K/V tile from a valid/ready producer into BRAM port A.
// Write port is registered; the address offset persists across tiles.
module store_bram_q_k_v #(
  parameter int ADDR_WIDTH       = 16,
  parameter int ORIGINAL_COLUMNS = 768,
  parameter int ORIGINAL_ROWS    = 512,
  parameter int NUM_BITS         = 8,
  parameter int DATA_WIDTH       = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_store,
  input  logic                  reset_addr_counter,
  input  logic [2:0]            Buffer_Select,
  input  logic                  Tiles_Control,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  store_done,
  output logic                  sel_err
);

  localparam int WPR       = ORIGINAL_COLUMNS * NUM_BITS / DATA_WIDTH;
  localparam int BUF_WORDS = ORIGINAL_ROWS * WPR;
  localparam int SHORT_LEN = 32 * WPR;
  localparam int CW        = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [CW-1:0]           offset;
  logic [CW-1:0]           beat;
  logic [CW-1:0]           last_beat;
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH-1:0]   sel_base;
  logic                    sel_ok;
  logic                    tile_short;
  logic                    fire;
  logic                    last;
  logic                    accept;

  always_comb begin
    sel_ok   = 1'b1;
    sel_base = '0;
    unique case (1'b1)
      (Buffer_Select == 3'b011): sel_base = '0;
      (Buffer_Select == 3'b100): sel_base = ADDR_WIDTH'(BUF_WORDS);
      (Buffer_Select == 3'b101): sel_base = ADDR_WIDTH'(2 * BUF_WORDS);
      default:                   sel_ok   = 1'b0;
    endcase
  end

  // A clear cycle never accepts a beat, so the producer keeps it.
  assign in_ready  = (state == WRITE) && !reset_addr_counter;
  assign fire      = in_valid && in_ready;
  assign last_beat = tile_short ? CW'(SHORT_LEN - 1) : CW'(BUF_WORDS - 1);
  assign last      = fire && (beat == last_beat);
  assign accept    = (state == IDLE) && start_store && !reset_addr_counter;

  always_comb begin
    state_nx = state;
    if (reset_addr_counter) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_store && sel_ok) state_nx = WRITE;
        WRITE:   if (last) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      offset     <= '0;
      beat       <= '0;
      base       <= '0;
      tile_short <= 1'b0;
      ena        <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      store_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      ena        <= fire;
      wea        <= fire;
      store_done <= last;
      sel_err    <= accept && !sel_ok;
      if (fire) begin
        addra  <= base + ADDR_WIDTH'(offset);
        dina   <= in_data;
        offset <= (offset == CW'(BUF_WORDS - 1)) ? '0 : offset + 1'b1;
        beat   <= beat + 1'b1;
      end
      if (reset_addr_counter) begin
        offset <= '0;
        beat   <= '0;
      end else if (accept && sel_ok) begin
        base       <= sel_base;
        tile_short <= Tiles_Control;
        beat       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_store_bram_q_k_v.sv
// Scoreboard bench for store_bram_q_k_v: directed tiles, stalls,
// selection errors and mid-tile counter clears.
module tb_store_bram_q_k_v;

  typedef struct packed {
    logic [15:0]  a;
    logic [255:0] d;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_store;
  logic         reset_addr_counter;
  logic [2:0]   Buffer_Select;
  logic         Tiles_Control;
  logic         in_valid;
  logic [255:0] in_data;
  logic         in_ready;
  logic         ena;
  logic         wea;
  logic [15:0]  addra;
  logic [255:0] dina;
  logic         store_done;
  logic         sel_err;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   done_seen = 0;
  int   done_exp  = 0;

  always #5 clk = ~clk;

  store_bram_q_k_v dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_store        (start_store),
    .reset_addr_counter (reset_addr_counter),
    .Buffer_Select      (Buffer_Select),
    .Tiles_Control      (Tiles_Control),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .ena                (ena),
    .wea                (wea),
    .addra              (addra),
    .dina               (dina),
    .store_done         (store_done),
    .sel_err            (sel_err)
  );

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wea) begin
        chk("write_expected", 256'(sb.size() != 0), 256'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("addra", 256'(addra), 256'(e.a));
          chk("dina", dina, e.d);
          chk("store_done", 256'(store_done), 256'(e.done));
          chk("ena", 256'(ena), 256'(1));
        end
      end
      if (store_done) begin
        done_seen++;
        chk("done_with_write", 256'(wea), 256'(1));
      end
    end
  end

  task automatic start(input logic [2:0] sel, input logic t);
    Buffer_Select = sel;
    Tiles_Control = t;
    start_store   = 1'b1;
    @(negedge clk);
    start_store   = 1'b0;
  endtask

  task automatic send(input logic [255:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 256'(in_ready), 256'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Streams n beats; data = i*mul+add; gap inserts a low-valid cycle.
  task automatic tile(input int base, input int off, input int n,
                      input int len, input int mul, input int add,
                      input bit gap);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.a    = 16'(base + (off + i) % 12288);
      e.d    = 256'(i * mul + add);
      e.done = (i == len - 1);
      if (e.done) done_exp++;
      sb.push_back(e);
      send(256'(i * mul + add));
      if (gap) begin
        in_valid = 1'b0;
        in_data  = '1;
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic settle(input string name);
    chk({name, "_queue_empty"}, 256'(sb.size()), 256'(0));
    chk({name, "_done_count"}, 256'(done_seen), 256'(done_exp));
    chk({name, "_idle"}, 256'(in_ready), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    start_store        = 1'b0;
    reset_addr_counter = 1'b0;
    Buffer_Select      = 3'b000;
    Tiles_Control      = 1'b0;
    in_valid           = 1'b0;
    in_data            = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_wea", 256'({ena, wea, store_done, sel_err}), 256'(0));
    chk("rst_addra", 256'(addra), 256'(0));
    chk("rst_dina", dina, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // K tile of 768 words
    start(3'b100, 1'b1);
    tile(12288, 0, 768, 768, 2, 2, 1'b0);
    settle("k_tile1");

    // second K tile continues the offset
    start(3'b100, 1'b1);
    tile(12288, 768, 768, 768, 3, 1000, 1'b0);
    settle("k_tile2");

    // full Q buffer after clearing the offset
    reset_addr_counter = 1'b1;
    @(negedge clk);
    reset_addr_counter = 1'b0;
    start(3'b011, 1'b0);
    tile(0, 0, 12288, 12288, 5, 7, 1'b0);
    settle("q_full");

    // V tile with stalls; offset wrapped back to 0
    start(3'b101, 1'b1);
    tile(24576, 0, 768, 768, 7, 3, 1'b1);
    settle("v_stall");

    // invalid select
    start(3'b000, 1'b1);
    chk("sel_err_pulse", 256'(sel_err), 256'(1));
    #1;
    chk("sel_err_ready", 256'(in_ready), 256'(0));
    @(negedge clk);
    chk("sel_err_once", 256'(sel_err), 256'(0));
    chk("sel_err_idle", 256'(in_ready), 256'(0));
    repeat (3) @(negedge clk);

    // abort after 10 beats; offset is 768 after the V tile
    start(3'b011, 1'b1);
    tile(0, 768, 10, 768, 11, 5, 1'b0);
    reset_addr_counter = 1'b1;
    in_valid           = 1'b1;
    in_data            = 256'hdead;
    #1;
    chk("clear_blocks_ready", 256'(in_ready), 256'(0));
    @(negedge clk);
    reset_addr_counter = 1'b0;
    in_valid           = 1'b0;
    repeat (3) @(negedge clk);
    settle("abort");

    // next start writes from base
    start(3'b100, 1'b1);
    tile(12288, 0, 768, 768, 13, 9, 1'b0);
    settle("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
